// File: rtl/mul3_mac_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul3_mac_seq_pkg
//   Shared definitions for the 3-bit multiply-accumulate stage.
//   Contents:
//     OPND_W   operand width of the array multiplier (3)
//     PROD_W   product width (2*OPND_W = 6, max value 49)
//     state_e  frame FSM encoding: ST_ACC=0, ST_DRAIN=1, ST_OUT=2
// -----------------------------------------------------------------------------
package mul3_mac_seq_pkg;

   localparam int OPND_W = 3;
   localparam int PROD_W = 2 * OPND_W;

   typedef enum logic [1:0] {
      ST_ACC   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_OUT   = 2'd2
   } state_e;

endpackage : mul3_mac_seq_pkg

// File: rtl/array_mul3_bip.sv
// -----------------------------------------------------------------------------
// array_mul3_bip
//   Purely combinational 3x3 unsigned array multiplier.
//   Ports:
//     a     in   OPND_W  unsigned multiplicand
//     b     in   OPND_W  unsigned multiplier
//     prod  out  PROD_W  a*b
// -----------------------------------------------------------------------------
module array_mul3_bip
   import mul3_mac_seq_pkg::*;
(
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   output logic [PROD_W-1:0] prod
);

   // One shifted partial product per multiplier bit, summed as an array.
   logic [PROD_W-1:0] pp [OPND_W];

   always_comb begin
      for (int i = 0; i < OPND_W; i++) begin
         pp[i] = b[i] ? (PROD_W'(a) << i) : '0;
      end
   end

   always_comb begin
      prod = '0;
      for (int i = 0; i < OPND_W; i++) begin
         prod = prod + pp[i];
      end
   end

endmodule : array_mul3_bip

// File: rtl/mul3_mac_seq.sv
// -----------------------------------------------------------------------------
// mul3_mac_seq
//   Sequential multiply-accumulate stage. Accepts 3-bit operand pairs over a
//   valid/ready handshake, registers each pair, multiplies it in the array
//   multiplier on the following cycle and accumulates N_TERMS products into a
//   saturating ACC_W-bit sum that is presented over a valid/ready handshake.
//   Parameters:
//     N_TERMS  operand pairs per frame (>=1)
//     ACC_W    accumulator width (>= PROD_W)
//   Ports:
//     clk        in   1       rising-edge clock
//     rst_n      in   1       synchronous active-low reset
//     in_valid   in   1       operand pair valid
//     in_ready   out  1       stage can accept a pair (ACC state, no clear)
//     a, b       in   3       unsigned operands
//     clear      in   1       synchronous frame flush
//     out_valid  out  1       acc_out holds a completed frame
//     out_ready  in   1       consumer takes the frame
//     acc_out    out  ACC_W   accumulated (saturated) sum
//     ovf        out  1       sticky saturation flag for the current frame
//     term_cnt   out  CNT_W   pairs accepted in the current frame
// -----------------------------------------------------------------------------
module mul3_mac_seq
   import mul3_mac_seq_pkg::*;
#(
   parameter int N_TERMS = 8,
   parameter int ACC_W   = 9,
   localparam int CNT_W  = $clog2(N_TERMS + 1)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   input  logic              clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              ovf,
   output logic [CNT_W-1:0]  term_cnt
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

   state_e              state_q;
   logic [ACC_W-1:0]    acc_q;
   logic                ovf_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                p_vld_q;
   logic [OPND_W-1:0]   a_q;
   logic [OPND_W-1:0]   b_q;

   logic [PROD_W-1:0]   prod;
   logic [ACC_W:0]      acc_sum_d;   // {saturated, sum}
   logic [CNT_W-1:0]    cnt_d;
   logic                hs_d;

   // Unsigned add with one guard bit; a carry into the guard bit clamps the
   // result to all-ones and flags saturation in the returned MSB.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                              input logic [PROD_W-1:0] p);
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + (ACC_W+1)'(p);
      if (sum[ACC_W]) begin
         return {1'b1, {ACC_W{1'b1}}};
      end
      return {1'b0, sum[ACC_W-1:0]};
   endfunction

   array_mul3_bip u_mul (
      .a    (a_q),
      .b    (b_q),
      .prod (prod)
   );

   // in_ready is masked by clear so a flush never swallows a new pair.
   assign in_ready  = (state_q == ST_ACC) && !clear;
   assign out_valid = (state_q == ST_OUT);
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;
   assign term_cnt  = cnt_q;

   always_comb begin
      hs_d      = in_valid && in_ready;
      cnt_d     = cnt_q + 1'b1;
      acc_sum_d = sat_add(acc_q, prod);
   end

   // Operand register: data only, loaded on an accepted handshake.
   always_ff @(posedge clk) begin
      if (hs_d) begin
         a_q <= a;
         b_q <= b;
      end
   end

   // Frame FSM, term counter and saturating accumulator.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         // Reset and clear both abandon the frame, discarding any pending
         // product, so no partial result can ever reach the output.
         state_q <= ST_ACC;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         p_vld_q <= 1'b0;
      end else begin
         case (state_q)
            ST_ACC: begin
               // The product of the pair taken last cycle is added now.
               if (p_vld_q) begin
                  acc_q <= acc_sum_d[ACC_W-1:0];
                  ovf_q <= ovf_q | acc_sum_d[ACC_W];
               end
               if (hs_d) begin
                  p_vld_q <= 1'b1;
                  cnt_q   <= cnt_d;
                  if (cnt_d == LAST_CNT) begin
                     state_q <= ST_DRAIN;
                  end
               end else begin
                  p_vld_q <= 1'b0;
               end
            end
            ST_DRAIN: begin
               // Fold in the last accepted pair before presenting the frame.
               if (p_vld_q) begin
                  acc_q <= acc_sum_d[ACC_W-1:0];
                  ovf_q <= ovf_q | acc_sum_d[ACC_W];
               end
               p_vld_q <= 1'b0;
               state_q <= ST_OUT;
            end
            ST_OUT: begin
               // Result is held until the consumer takes it.
               if (out_ready) begin
                  acc_q   <= '0;
                  ovf_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= ST_ACC;
               end
            end
            default: begin
               state_q <= ST_ACC;
               p_vld_q <= 1'b0;
            end
         endcase
      end
   end

endmodule : mul3_mac_seq

// File: tb/tb_mul3_mac_seq.sv
module tb_mul3_mac_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] a;
   logic [2:0] b;
   logic       clear;
   logic       out_ready;

   logic       in_ready, out_valid, ovf;
   logic [8:0] acc_out;
   logic [3:0] term_cnt;

   logic       in_ready6, out_valid6, ovf6;
   logic [5:0] acc_out6;
   logic [3:0] term_cnt6;

   always #5 clk = ~clk;

   mul3_mac_seq #(.N_TERMS(8), .ACC_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
      .acc_out(acc_out), .ovf(ovf), .term_cnt(term_cnt)
   );

   // Narrow-accumulator copy driven by the same stimulus to exercise saturation.
   mul3_mac_seq #(.N_TERMS(8), .ACC_W(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready6),
      .a(a), .b(b), .clear(clear), .out_valid(out_valid6), .out_ready(out_ready),
      .acc_out(acc_out6), .ovf(ovf6), .term_cnt(term_cnt6)
   );

   typedef struct packed {
      logic [8:0] acc9;
      logic       ovf9;
      logic [5:0] acc6;
      logic       ovf6;
   } exp_t;

   exp_t q[$];
   int   ncmp  = 0;
   int   nmiss = 0;

   task automatic chk(input string nm, input int act, input int req);
      ncmp++;
      if (act != req) begin
         nmiss++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   // Products are non-negative, so a saturated frame ends at all-ones.
   function automatic exp_t mk(input int total);
      exp_t e;
      e.acc9 = (total > 511) ? 9'd511 : 9'(total);
      e.ovf9 = (total > 511);
      e.acc6 = (total > 63) ? 6'd63 : 6'(total);
      e.ovf6 = (total > 63);
      return e;
   endfunction

   // Monitor: pops one expectation per output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_frame", 1, 0);
            end else begin
               e = q.pop_front();
               chk("acc_out",    int'(acc_out),  int'(e.acc9));
               chk("ovf",        int'(ovf),      int'(e.ovf9));
               chk("out_valid6", int'(out_valid6), 1);
               chk("acc_out6",   int'(acc_out6), int'(e.acc6));
               chk("ovf6",       int'(ovf6),     int'(e.ovf6));
               chk("term_cnt6",  int'(term_cnt6), 8);
               chk("in_ready6",  int'(in_ready6), 0);
            end
         end
      end
   end

   task automatic send(input logic [2:0] x, input logic [2:0] y);
      int t = 0;
      @(negedge clk);
      a = x;
      b = y;
      in_valid = 1'b1;
      #1;
      while (!in_ready && t < 40) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (t >= 40) chk("accept_timeout", t, 0);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      int t;
      int s;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; clear = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_acc",      int'(acc_out),   0);
      chk("rst_cnt",      int'(term_cnt),  0);
      chk("rst_ovf",      int'(ovf),       0);
      chk("rst_out_vld",  int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready),  1);
      rst_n = 1'b1;

      // 1: (1,1)..(7,7),(0,5) -> 140, latency check
      q.push_back(mk(140));
      for (int i = 1; i <= 7; i++) send(3'(i), 3'(i));
      send(3'd0, 3'd5);
      idle();
      chk("t1_drain_out_vld", int'(out_valid), 0);
      chk("t1_drain_in_ready", int'(in_ready), 0);
      chk("t1_term_cnt", int'(term_cnt), 8);
      @(negedge clk);
      chk("t1_out_vld", int'(out_valid), 1);
      chk("t1_acc", int'(acc_out), 140);
      repeat (2) @(negedge clk);

      // 2: 8x(7,7) -> 392 (63 + ovf on the narrow copy)
      q.push_back(mk(392));
      for (int i = 0; i < 8; i++) send(3'd7, 3'd7);
      idle();
      repeat (3) @(negedge clk);

      // 3: backpressure in OUT, 8x(3,2) -> 48
      out_ready = 1'b0;
      q.push_back(mk(48));
      for (int i = 0; i < 8; i++) send(3'd3, 3'd2);
      idle();
      t = 0;
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) chk("t3_out_timeout", t, 0);
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_vld", int'(out_valid), 1);
         chk("t3_hold_acc", int'(acc_out), 48);
         chk("t3_hold_rdy", int'(in_ready), 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_after_acc", int'(acc_out), 0);
      chk("t3_after_rdy", int'(in_ready), 1);
      chk("t3_after_vld", int'(out_valid), 0);

      // 4: clear after 3x(2,3) with a 4th pair offered alongside clear
      for (int i = 0; i < 3; i++) send(3'd2, 3'd3);
      @(negedge clk);
      a = 3'd2; b = 3'd3; in_valid = 1'b1; clear = 1'b1;
      #1;
      chk("t4_clear_rdy", int'(in_ready), 0);
      @(negedge clk);
      clear = 1'b0; in_valid = 1'b0;
      chk("t4_cnt", int'(term_cnt), 0);
      chk("t4_acc", int'(acc_out), 0);
      chk("t4_ovf", int'(ovf), 0);
      @(negedge clk);
      chk("t4_acc_late", int'(acc_out), 0);
      chk("t4_cnt_late", int'(term_cnt), 0);
      q.push_back(mk(8));
      for (int i = 0; i < 8; i++) send(3'd1, 3'd1);
      idle();
      repeat (3) @(negedge clk);

      // 5: reset during DRAIN, no frame may emerge
      for (int i = 0; i < 8; i++) send(3'd5, 3'd5);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      chk("t5_drain_vld", int'(out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("t5_acc", int'(acc_out), 0);
      chk("t5_cnt", int'(term_cnt), 0);
      chk("t5_ovf", int'(ovf), 0);
      chk("t5_vld", int'(out_valid), 0);
      chk("t5_rdy", int'(in_ready), 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_no_pulse", int'(out_valid), 0);
      end

      // 6: all 64 pairs, one frame per multiplicand, in_valid toggling
      for (int x = 0; x < 8; x++) begin
         s = 0;
         for (int y = 0; y < 8; y++) s += x * y;
         q.push_back(mk(s));
         for (int y = 0; y < 8; y++) begin
            send(3'(x), 3'(y));
            idle();
         end
      end

      t = 0;
      while (q.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("frames_left", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", ncmp, nmiss);
      $finish;
   end

endmodule : tb_mul3_mac_seq
